// File: rtl/mem_bus_ctrl.sv
// Data-memory access stage behind the MMU: runs one multi-cycle bus read or
// write with byte lanes. The pipeline is stalled until the access completes.
// Faulting or misaligned requests are rejected without a bus cycle.
//
// state  | meaning
// IDLE   | waiting for a request; faults and misalignment reported combinationally
// ACCESS | bus strobe active; wait-state counter running; timeout watchdog armed
// DONE   | strobes released, rdata_o valid, bus_err_o reports a timeout abort
module mem_bus_ctrl #(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [1:0]  size_i,
  input  logic        sign_i,
  input  logic [31:0] paddr_i,
  input  logic [31:0] wdata_i,
  input  logic        mmu_error_i,
  output logic [31:0] rdata_o,
  output logic        stall_o,
  output logic        mmu_fault_o,
  output logic        addr_err_o,
  output logic        bus_err_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  output logic [3:0]  bus_be_o,
  output logic        bus_rd_o,
  output logic        bus_wr_o,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_ready_i
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [7:0] WAIT_C  = 8'(WAIT_CYCLES);
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        sign_q, sign_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic [31:0] rdata_q, rdata_d;
  logic        berr_q, berr_d;

  logic        misalign;
  logic        start;
  logic [3:0]  be_new;
  logic [31:0] wdata_new;
  logic [31:0] load_ext;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Request decode: alignment, byte lanes and lane-replicated store data.
  always_comb begin
    misalign  = 1'b0;
    be_new    = 4'b1111;
    wdata_new = wdata_i;
    case (size_i)
      2'b00: begin
        be_new    = 4'b0001 << paddr_i[1:0];
        wdata_new = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        misalign  = paddr_i[0];
        be_new    = 4'b0011 << paddr_i[1:0];
        wdata_new = {2{wdata_i[15:0]}};
      end
      default: misalign = (paddr_i[1:0] != 2'b00);
    endcase
    start = req_i && !mmu_error_i && !misalign;
  end

  // Load alignment: pick the addressed lane, then sign- or zero-extend.
  always_comb begin
    ld_byte  = bus_rdata_i[{addr_q[1:0], 3'b000} +: 8];
    ld_half  = bus_rdata_i[{addr_q[1], 4'b0000} +: 16];
    load_ext = bus_rdata_i;
    case (size_q)
      2'b00:   load_ext = {{24{sign_q & ld_byte[7]}}, ld_byte};
      2'b01:   load_ext = {{16{sign_q & ld_half[15]}}, ld_half};
      default: load_ext = bus_rdata_i;
    endcase
  end

  // Next-state logic for the access sequencer and its registered outputs.
  always_comb begin
    state_d = state_q;
    cnt_d   = 8'd0;
    we_d    = we_q;
    size_d  = size_q;
    sign_d  = sign_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    rdata_d = rdata_q;
    berr_d  = berr_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ACCESS;
          we_d    = we_i;
          size_d  = size_i;
          sign_d  = sign_i;
          addr_d  = paddr_i;
          wdata_d = wdata_new;
          be_d    = be_new;
          rd_d    = !we_i;
          wr_d    = we_i;
        end
      end
      ACCESS: begin
        cnt_d = cnt_q + 8'd1;
        // Ready is checked before the watchdog so a coincident ready still completes.
        if (cnt_q >= WAIT_C && bus_ready_i) begin
          state_d = DONE;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          if (!we_q) rdata_d = load_ext;
        end else if (cnt_q == TO_LAST) begin
          state_d = DONE;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          berr_d  = 1'b1;
          rdata_d = 32'd0;
        end
      end
      DONE: begin
        state_d = IDLE;
        berr_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset abandons any transfer in flight.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      sign_q  <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      be_q    <= 4'd0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      rdata_q <= 32'd0;
      berr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      size_q  <= size_d;
      sign_q  <= sign_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      rdata_q <= rdata_d;
      berr_q  <= berr_d;
    end
  end

  // The IDLE-cycle indications are gated by clrn so reset forces them low at once.
  assign stall_o     = (state_q == ACCESS) || (clrn && state_q == IDLE && start);
  assign mmu_fault_o = clrn && state_q == IDLE && req_i && mmu_error_i;
  assign addr_err_o  = clrn && state_q == IDLE && req_i && !mmu_error_i && misalign;
  assign bus_err_o   = berr_q;
  assign rdata_o     = rdata_q;
  assign bus_addr_o  = {addr_q[31:2], 2'b00};
  assign bus_wdata_o = wdata_q;
  assign bus_be_o    = be_q;
  assign bus_rd_o    = rd_q;
  assign bus_wr_o    = wr_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
module tb_mem_bus_ctrl;
  localparam int WAITC = 2;
  localparam int TOUT  = 255;

  logic        clk = 1'b0;
  logic        clrn = 1'b0;
  logic        req_i = 1'b0, we_i = 1'b0, sign_i = 1'b0, mmu_error_i = 1'b0;
  logic [1:0]  size_i = 2'b00;
  logic [31:0] paddr_i = '0, wdata_i = '0, bus_rdata_i = '0;
  logic        bus_ready_i = 1'b0;
  logic [31:0] rdata_o, bus_addr_o, bus_wdata_o;
  logic        stall_o, mmu_fault_o, addr_err_o, bus_err_o, bus_rd_o, bus_wr_o;
  logic [3:0]  bus_be_o;

  mem_bus_ctrl #(.WAIT_CYCLES(WAITC), .TIMEOUT(TOUT)) dut (
    .clk(clk), .clrn(clrn), .req_i(req_i), .we_i(we_i), .size_i(size_i),
    .sign_i(sign_i), .paddr_i(paddr_i), .wdata_i(wdata_i), .mmu_error_i(mmu_error_i),
    .rdata_o(rdata_o), .stall_o(stall_o), .mmu_fault_o(mmu_fault_o),
    .addr_err_o(addr_err_o), .bus_err_o(bus_err_o), .bus_addr_o(bus_addr_o),
    .bus_wdata_o(bus_wdata_o), .bus_be_o(bus_be_o), .bus_rd_o(bus_rd_o),
    .bus_wr_o(bus_wr_o), .bus_rdata_i(bus_rdata_i), .bus_ready_i(bus_ready_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sign;
    logic [31:0] paddr;
    logic [31:0] wdata;
    logic        mmu;
    logic [31:0] brdata;
    logic [31:0] exp_rdata;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic        exp_fault;
    logic        exp_aerr;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        chk_rdata;
  } sb_t;

  sb_t  sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [1:0] size, input logic sign,
                              input logic [31:0] paddr, input logic [31:0] wdata,
                              input logic mmu, input logic [31:0] brdata,
                              input logic [31:0] erd, input logic [3:0] ebe,
                              input logic [31:0] ewd, input logic ef, input logic ea);
    vec_t v;
    v.we = we; v.size = size; v.sign = sign; v.paddr = paddr; v.wdata = wdata;
    v.mmu = mmu; v.brdata = brdata; v.exp_rdata = erd; v.exp_be = ebe;
    v.exp_wdata = ewd; v.exp_fault = ef; v.exp_aerr = ea;
    return v;
  endfunction

  // One full access from the IDLE request cycle through DONE and back to IDLE.
  task automatic do_access(input vec_t v, input bit rdy, input int exp_acc);
    int    n;
    sb_t   e;
    @(negedge clk);
    req_i = 1'b1; we_i = v.we; size_i = v.size; sign_i = v.sign; paddr_i = v.paddr;
    wdata_i = v.wdata; mmu_error_i = v.mmu; bus_rdata_i = v.brdata; bus_ready_i = rdy;
    #1;
    check("mmu_fault", {31'd0, mmu_fault_o}, {31'd0, v.exp_fault});
    check("addr_err", {31'd0, addr_err_o}, {31'd0, v.exp_aerr});
    check("stall_req", {31'd0, stall_o}, {31'd0, !(v.exp_fault || v.exp_aerr)});
    if (v.exp_fault || v.exp_aerr) begin
      @(posedge clk); #1;
      req_i = 1'b0; mmu_error_i = 1'b0;
      check("rejected_strobes", {30'd0, bus_rd_o, bus_wr_o}, 32'd0);
      check("rejected_stall", {31'd0, stall_o}, 32'd0);
      return;
    end
    e.rdata = rdy ? v.exp_rdata : 32'd0;
    e.err = !rdy;
    e.chk_rdata = !v.we || !rdy;
    sb_q.push_back(e);
    @(posedge clk); #1;
    // Inputs wander during ACCESS and must be ignored.
    req_i = 1'b0; paddr_i = ~v.paddr; wdata_i = ~v.wdata; we_i = ~v.we; size_i = ~v.size;
    n = 0;
    while (stall_o && n < 400) begin
      if (n == 0) begin
        check("bus_rd", {31'd0, bus_rd_o}, {31'd0, !v.we});
        check("bus_wr", {31'd0, bus_wr_o}, {31'd0, v.we});
        check("bus_addr", bus_addr_o, {v.paddr[31:2], 2'b00});
        check("bus_be", {28'd0, bus_be_o}, {28'd0, v.exp_be});
        if (v.we) check("bus_wdata", bus_wdata_o, v.exp_wdata);
      end
      n++;
      @(posedge clk); #1;
    end
    check("access_cycles", n, exp_acc);
    check("done_strobes", {30'd0, bus_rd_o, bus_wr_o}, 32'd0);
    if (sb_q.size() == 0) begin
      n_checks++; n_errors++;
      $display("FAIL scoreboard_empty: got 0 entries expected 1");
    end else begin
      e = sb_q.pop_front();
      check("bus_err", {31'd0, bus_err_o}, {31'd0, e.err});
      if (e.chk_rdata) check("rdata", rdata_o, e.rdata);
    end
    @(posedge clk); #1;
    check("idle_after_done", {29'd0, bus_err_o, stall_o, bus_rd_o | bus_wr_o}, 32'd0);
    bus_ready_i = 1'b0;
  endtask

  initial begin
    vecs[0]  = mk(0, 2'b10, 0, 32'h0000_1004, 32'h0, 0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 4'b1111, 32'h0, 0, 0);
    vecs[1]  = mk(0, 2'b00, 1, 32'h0000_2003, 32'h0, 0, 32'h80FF_FFFF, 32'hFFFF_FF80, 4'b1000, 32'h0, 0, 0);
    vecs[2]  = mk(0, 2'b00, 0, 32'h0000_2003, 32'h0, 0, 32'h80FF_FFFF, 32'h0000_0080, 4'b1000, 32'h0, 0, 0);
    vecs[3]  = mk(1, 2'b01, 0, 32'h0000_3002, 32'h1234_ABCD, 0, 32'h0, 32'h0, 4'b1100, 32'hABCD_ABCD, 0, 0);
    vecs[4]  = mk(0, 2'b10, 0, 32'h0000_4001, 32'h0, 1, 32'h0, 32'h0, 4'b0000, 32'h0, 1, 0);
    vecs[5]  = mk(0, 2'b01, 0, 32'h0000_5001, 32'h0, 0, 32'h0, 32'h0, 4'b0000, 32'h0, 0, 1);
    vecs[6]  = mk(1, 2'b00, 0, 32'h0000_6001, 32'h0000_00A5, 0, 32'h0, 32'h0, 4'b0010, 32'hA5A5_A5A5, 0, 0);
    vecs[7]  = mk(0, 2'b01, 1, 32'h0000_7002, 32'h0, 0, 32'h8001_1234, 32'hFFFF_8001, 4'b1100, 32'h0, 0, 0);
    vecs[8]  = mk(0, 2'b01, 0, 32'h0000_8000, 32'h0, 0, 32'h8001_F234, 32'h0000_F234, 4'b0011, 32'h0, 0, 0);
    vecs[9]  = mk(0, 2'b00, 0, 32'h0000_9001, 32'h0, 0, 32'h1122_3344, 32'h0000_0033, 4'b0010, 32'h0, 0, 0);
    vecs[10] = mk(1, 2'b11, 0, 32'h0000_0010, 32'hCAFE_F00D, 0, 32'h0, 32'h0, 4'b1111, 32'hCAFE_F00D, 0, 0);

    // Reset state, with a request pending to show the IDLE outputs are held low.
    req_i = 1'b1; size_i = 2'b10; paddr_i = 32'h100;
    #12;
    check("reset_outputs", {25'd0, stall_o, mmu_fault_o, addr_err_o, bus_err_o, bus_rd_o, bus_wr_o, |bus_be_o}, 32'd0);
    check("reset_rdata", rdata_o, 32'd0);
    req_i = 1'b0;
    @(negedge clk); clrn = 1'b1;

    for (int i = 0; i < 11; i++) do_access(vecs[i], 1'b1, WAITC + 1);

    // Reset mid-ACCESS: strobes, stall and rdata drop at once.
    @(negedge clk);
    req_i = 1'b1; we_i = 1'b0; size_i = 2'b10; paddr_i = 32'h0000_0200; mmu_error_i = 1'b0;
    bus_ready_i = 1'b0;
    @(posedge clk); #1; req_i = 1'b0;
    check("pre_reset_rd", {31'd0, bus_rd_o}, 32'd1);
    @(negedge clk); clrn = 1'b0; #1;
    check("midreset_outputs", {29'd0, stall_o, bus_rd_o, bus_wr_o}, 32'd0);
    check("midreset_rdata", rdata_o, 32'd0);
    @(negedge clk); clrn = 1'b1;
    do_access(vecs[0], 1'b1, WAITC + 1);

    // Timeout: ready never arrives.
    do_access(vecs[1], 1'b0, TOUT);

    check("scoreboard_drained", sb_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/mem_bus_ctrl.md
Name:
mem_bus_ctrl

Overview:
Data-memory access stage directly downstream of the MMU. It consumes the translated physical address and the MMU fault flag, runs a multi-cycle read/write bus transaction with byte lanes, and stalls the pipeline until the transaction completes. It returns aligned, sign/zero-extended load data to the MEM stage and flags faults without touching the bus.

Parameters:
WAIT_CYCLES, 2, minimum cycles in ACCESS before bus_ready_i is sampled (range 0..15).
TIMEOUT, 255, ACCESS cycles without bus_ready_i before the access is aborted with bus_err_o (range WAIT_CYCLES+1..255).

Ports:
clk  in  1  system clock; all state updates on posedge.
clrn  in  1  asynchronous active-low reset.
req_i  in  1  valid load/store in MEM stage.
we_i  in  1  1 = store, 0 = load.
size_i  in  2  00 byte, 01 half, 10 word; 11 is treated as word.
sign_i  in  1  1 = sign-extend load result.
paddr_i  in  32  physical address from the MMU.
wdata_i  in  32  store data, right-justified.
mmu_error_i  in  1  MMU translation fault for paddr_i.
rdata_o  out  32  load result; valid in the DONE cycle.
stall_o  out  1  holds the pipeline, including MMU register updates.
mmu_fault_o  out  1  access dropped due to an MMU fault.
addr_err_o  out  1  access dropped due to misalignment.
bus_err_o  out  1  access aborted by timeout.
bus_addr_o  out  32  {paddr[31:2],2'b00}.
bus_wdata_o  out  32  store data replicated across byte lanes.
bus_be_o  out  4  byte enables; lane = paddr[1:0], little-endian.
bus_rd_o  out  1  read strobe.
bus_wr_o  out  1  write strobe.
bus_rdata_i  in  32  read data.
bus_ready_i  in  1  slave completion.

Behaviour:
- Reset (async, clrn=0): state IDLE. All outputs 0 immediately, including bus strobes, stall_o, rdata_o and the error flags. Counters cleared. Reset during ACCESS abandons the transfer with no completion.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - If req_i=1 and mmu_error_i=1: mmu_fault_o=1 combinationally, stall_o=0, no bus cycle, stay IDLE.
  - Else if misaligned (half with paddr[0]=1, or word with paddr[1:0]!=0): addr_err_o=1 combinationally, stall_o=0, no bus cycle.
  - mmu_fault has priority over addr_err.
  - Else if req_i=1: stall_o=1 combinationally this cycle. Latch we/size/sign/paddr/wdata and compute be. Go to ACCESS next edge.
- ACCESS:
  - Drive bus_rd_o=~we or bus_wr_o=we, plus registered bus_addr_o, bus_be_o and bus_wdata_o. stall_o=1.
  - An 8-bit counter increments every cycle, starting at 0.
  - bus_ready_i is ignored while counter < WAIT_CYCLES.
  - Once counter >= WAIT_CYCLES and bus_ready_i=1: capture the load result and go to DONE.
  - If counter reaches TIMEOUT first: set the bus_err flag, force rdata to 0 and go to DONE.
  - If ready and timeout coincide, ready wins.
- DONE:
  - Strobes deasserted, stall_o=0, rdata_o valid.
  - bus_err_o=1 if the access was aborted by timeout.
  - Return to IDLE next edge. The pipeline advances on this edge, so req_i seen in the following IDLE cycle is a new access.
- Byte enables: byte = 0001<<a; half = 0011<<a; word = 1111, where a = paddr[1:0].
- Store data: byte replicated ×4, half replicated ×2.
- Load data: select the lane by paddr[1:0], then sign- or zero-extend per sign_i. rdata_o holds its value until the next DONE.
- Latency: a transfer with ready already high completes in 2+WAIT_CYCLES stall cycles: the IDLE request cycle, then WAIT_CYCLES+1 ACCESS cycles.
- req_i is not sampled outside IDLE. Inputs may change during ACCESS without effect.

Test Plan:
- Word load, paddr=0x00001004, WAIT_CYCLES=2, ready held high:
  - bus_addr_o=0x00001004, be=1111, bus_rd_o high for 3 cycles, stall_o high for 4 cycles.
  - rdata_o=bus_rdata_i in DONE.
- Byte load, sign_i=1, paddr=...03, bus_rdata_i=0x80FFFFFF -> be=1000, rdata_o=0xFFFFFF80. Same access with sign_i=0 -> rdata_o=0x00000080.
- Half store, wdata=0x1234ABCD, paddr=...02 -> bus_wdata_o=0xABCDABCD, be=1100, bus_wr_o asserted, bus_rd_o=0.
- req_i with mmu_error_i=1 and also misaligned -> mmu_fault_o=1, addr_err_o=0, stall_o=0, no strobe. Half access at ...01 with no MMU fault -> addr_err_o=1.
- ready never asserted, TIMEOUT=255 -> abort after 255 ACCESS cycles, bus_err_o=1 in DONE, rdata_o=0, FSM back in IDLE.
- clrn pulsed low mid-ACCESS -> strobes and stall_o drop to 0 immediately. After release, the next req_i starts a fresh access.
